// File: rtl/fp_to_posit_pipe_if.sv
// Streaming bus for fp_to_posit_pipe: float operand in, posit result out.
// With FP2P_FLAGS_EN defined the result side also carries o_inexact/o_sat/o_nar.
interface fp_to_posit_pipe_if #(
  parameter int FPWID = 32,
  parameter int PWID  = 16
) ();
  logic             i_valid;
  logic             i_ready;
  logic [FPWID-1:0] i;
  logic             o_valid;
  logic             o_ready;
  logic [PWID-1:0]  o;
`ifdef FP2P_FLAGS_EN
  logic             o_inexact;
  logic             o_sat;
  logic             o_nar;
`endif

  modport slave (
    input  i_valid, i, o_ready,
    output i_ready, o_valid, o
`ifdef FP2P_FLAGS_EN
    , output o_inexact, o_sat, o_nar
`endif
  );

  modport master (
    output i_valid, i, o_ready,
    input  i_ready, o_valid, o
`ifdef FP2P_FLAGS_EN
    , input o_inexact, o_sat, o_nar
`endif
  );
endinterface

// File: rtl/fp_to_posit_pipe.sv
// 3-stage IEEE-754 -> posit converter (decompose / scale / pack+round), RNE with saturation.
// Optional result flags o_inexact/o_sat/o_nar are built only when FP2P_FLAGS_EN is defined.
module fp_to_posit_pipe #(
  parameter int FPWID = 32,
  parameter int PWID  = 16,
  parameter int ES    = 1
) (
  input  logic              clk,
  input  logic              rst,
  fp_to_posit_pipe_if.slave bus
);
  localparam int EXPW     = (FPWID == 16) ? 5 : (FPWID == 64) ? 11 : 8;
  localparam int FRACW    = FPWID - EXPW - 1;
  localparam int SIGW     = FRACW + 1;
  localparam int BIAS     = (1 << (EXPW - 1)) - 1;
  localparam int LZW      = $clog2(SIGW + 1);
  localparam int SW       = EXPW + 2;
  localparam int ESW      = (ES > 0) ? ES : 1;
  localparam int RLW      = $clog2(PWID);
  localparam int MAXSCALE = (PWID - 2) << ES;
  localparam int TW       = 1 + ES + FRACW;
  localparam int FW       = 2 * PWID + TW;

  if (!(FPWID == 16 || FPWID == 32 || FPWID == 64)) begin : g_bad_fpwid
    $error("fp_to_posit_pipe: unsupported FPWID %0d", FPWID);
  end
  if (PWID < 8 || PWID > 64 || ES < 0 || ES > 4) begin : g_bad_posit
    $error("fp_to_posit_pipe: unsupported PWID %0d / ES %0d", PWID, ES);
  end

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             nar;
    logic [EXPW-1:0]  exp;
    logic [LZW-1:0]   lz;
    logic [FRACW-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero;
    logic             nar;
    logic             sat_hi;
    logic             sat_lo;
    logic             neg;
    logic [RLW-1:0]   rl;
    logic [ESW-1:0]   e;
    logic [FRACW-1:0] frac;
  } s2_t;

  // Stage n may load when empty or when stage n+1 loads; bubbles collapse.
  logic [3:1] vld_pipe, ld;
  assign ld[3]       = ~vld_pipe[3] | bus.o_ready;
  assign ld[2]       = ~vld_pipe[2] | ld[3];
  assign ld[1]       = ~vld_pipe[1] | ld[2];
  assign bus.i_ready = ld[1];
  assign bus.o_valid = vld_pipe[3];

  // ---------------- S1: decompose, classify, normalise
  s1_t              s1_d, s1_q;
  logic [EXPW-1:0]  ex;
  logic [FRACW-1:0] fr;
  logic [SIGW-1:0]  sig;
  logic [LZW-1:0]   lz;

  always_comb begin
    ex  = bus.i[FPWID-2 -: EXPW];
    fr  = bus.i[FRACW-1:0];
    sig = {(ex != '0), fr};
    lz  = LZW'(SIGW);
    for (int b = 0; b < SIGW; b++)
      if (sig[b]) lz = LZW'(SIGW - 1 - b);
    s1_d      = '0;
    s1_d.sign = bus.i[FPWID-1];
    s1_d.zero = (ex == '0) && (fr == '0);
    s1_d.nar  = &ex;
    // Subnormals behave as exponent 1 with a zero hidden bit.
    s1_d.exp  = (ex == '0) ? EXPW'(1) : ex;
    s1_d.lz   = lz;
    // Hidden bit leaves the top after normalisation; only the fraction below it is kept.
    s1_d.frac = fr << lz;
  end

  // ---------------- S2: scale, regime run length, range check
  s2_t                  s2_d, s2_q;
  logic signed [SW-1:0] scale;
  logic signed [31:0]   sc, k;
  int                   rl;

  always_comb begin
    scale = SW'(s1_q.exp) - SW'(BIAS) - SW'(s1_q.lz);
    sc    = {{(32-SW){scale[SW-1]}}, scale};
    k     = sc >>> ES;
    rl    = k[31] ? -k : k + 1;
    if (rl > PWID - 1) rl = PWID - 1;
    s2_d        = '0;
    s2_d.sign   = s1_q.sign;
    s2_d.zero   = s1_q.zero;
    s2_d.nar    = s1_q.nar;
    s2_d.sat_hi = sc > MAXSCALE;
    s2_d.sat_lo = sc < -MAXSCALE;
    s2_d.neg    = k[31];
    s2_d.rl     = RLW'(rl);
    s2_d.e      = ESW'(sc);
    s2_d.frac   = s1_q.frac;
  end

  // ---------------- S3: pack, round to nearest even, saturate, apply sign
  logic [TW-1:0]   t;
  logic [FW-1:0]   wide;
  logic [PWID-2:0] body, mag;
  logic [PWID-1:0] sum, res;
  logic            guard, sticky, inc, cy, zro;

  always_comb begin
    // Terminating regime bit sits above {e, frac}; shifting in the run fills the regime.
    t          = '0;
    t[TW-1]    = s2_q.neg;
    t[FRACW-1:0] = s2_q.frac;
    for (int b = 0; b < ES; b++) t[FRACW + b] = s2_q.e[b];
    wide = {t, {(2*PWID){1'b0}}} >> s2_q.rl;
    if (!s2_q.neg) wide = wide | ~({FW{1'b1}} >> s2_q.rl);
    body   = wide[FW-1 -: PWID-1];
    guard  = wide[FW-PWID];
    sticky = |wide[FW-PWID-1:0];
    inc    = guard & (sticky | body[0]);
    sum    = {1'b0, body} + PWID'(inc);
    cy     = sum[PWID-1];
    zro    = (sum == '0);
    if (s2_q.sat_hi || cy)      mag = '1;
    else if (s2_q.sat_lo || zro) mag = (PWID-1)'(1);
    else                        mag = sum[PWID-2:0];
    if (s2_q.zero)      res = '0;
    else if (s2_q.nar)  res = {1'b1, {(PWID-1){1'b0}}};
    else if (s2_q.sign) res = -{1'b0, mag};
    else                res = {1'b0, mag};
  end

  logic [PWID-1:0] o_q;
  assign bus.o = o_q;

`ifdef FP2P_FLAGS_EN
  logic inexact_q, sat_q, nar_q, fin, sat_any;
  assign fin           = ~s2_q.zero & ~s2_q.nar;
  assign sat_any       = s2_q.sat_hi | s2_q.sat_lo | cy | zro;
  assign bus.o_inexact = inexact_q;
  assign bus.o_sat     = sat_q;
  assign bus.o_nar     = nar_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      o_q      <= '0;
`ifdef FP2P_FLAGS_EN
      inexact_q <= 1'b0;
      sat_q     <= 1'b0;
      nar_q     <= 1'b0;
`endif
    end else begin
      if (ld[1]) vld_pipe[1] <= bus.i_valid;
      if (ld[2]) vld_pipe[2] <= vld_pipe[1];
      if (ld[3]) vld_pipe[3] <= vld_pipe[2];
      if (ld[3] && vld_pipe[2]) begin
        o_q <= res;
`ifdef FP2P_FLAGS_EN
        inexact_q <= fin & (guard | sticky | sat_any);
        sat_q     <= fin & sat_any;
        nar_q     <= s2_q.nar;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld[1]) s1_q <= s1_d;
    if (ld[2]) s2_q <= s2_d;
  end
endmodule

// File: tb/tb_fp_to_posit_pipe.sv
// Scoreboard bench for fp_to_posit_pipe (FPWID=32, PWID=16, ES=1) with a bit-string posit model.
module tb_fp_to_posit_pipe;
  localparam int FPWID = 32, PWID = 16, ES = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_to_posit_pipe_if #(.FPWID(FPWID), .PWID(PWID)) bus ();
  fp_to_posit_pipe #(.FPWID(FPWID), .PWID(PWID), .ES(ES)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [15:0] p;
    logic        inx;
    logic        sat;
    logic        nar;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ordy = 1'b0;

  // Posit(16,1) from the float's exact value M*2^E, built as a bit string and rounded RNE.
  function automatic exp_t model(input logic [31:0] f);
    exp_t r;
    bit   q[$];
    int   e8, m, ex2, msb, sc, em, k, mag;
    bit   g, st, sat;
    r = '0; sat = 0; mag = 0;
    e8 = int'(f[30:23]);
    m  = int'(f[22:0]);
    if (e8 == 255) begin r.p = 16'h8000; r.nar = 1'b1; return r; end
    if (e8 == 0 && m == 0) return r;
    if (e8 == 0) ex2 = -149;
    else begin m += (1 << 23); ex2 = e8 - 150; end
    msb = 0;
    for (int b = 0; b < 24; b++) if (m[b]) msb = b;
    sc = ex2 + msb;
    if (sc > 28) begin mag = 'h7FFF; sat = 1; end
    else if (sc < -28) begin mag = 1; sat = 1; end
    else begin
      em = ((sc % 2) + 2) % 2;
      k  = (sc - em) / 2;
      if (k >= 0) begin repeat (k + 1) q.push_back(1'b1); q.push_back(1'b0); end
      else begin repeat (-k) q.push_back(1'b0); q.push_back(1'b1); end
      q.push_back(em[0]);
      for (int b = msb - 1; b >= 0; b--) q.push_back(m[b]);
      while (q.size() < 17) q.push_back(1'b0);
      for (int b = 0; b < 15; b++) mag = mag * 2 + int'(q[b]);
      g = q[15]; st = 0;
      for (int b = 16; b < q.size(); b++) st |= q[b];
      r.inx = g | st;
      if (g && (st || mag[0])) mag++;
      if (mag == 'h8000) begin mag = 'h7FFF; sat = 1; end
      if (mag == 0) begin mag = 1; sat = 1; end
    end
    if (sat) r.inx = 1'b1;
    r.sat = sat;
    r.p = f[31] ? 16'(-mag) : 16'(mag);
    return r;
  endfunction

  task automatic send(input logic [31:0] w, input exp_t e);
    int n = 0;
    @(negedge clk);
    bus.i = w; bus.i_valid = 1'b1;
    #1;
    while (!bus.i_ready && n < 500) begin @(negedge clk); #1; n++; end
    if (bus.i_ready) exp_q.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout i_ready=%0b required 1", bus.i_ready);
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (rand_ordy) bus.o_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops on every output transfer, checks order/value and hold-while-stalled.
  initial begin
    logic        held;
    logic [15:0] hv;
    exp_t        e;
    held = 1'b0; hv = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) held = 1'b0;
      else begin
        if (held && bus.o_valid) begin
          checks++;
          if (bus.o !== hv) begin
            errors++;
            $display("FAIL hold o=%h required %h", bus.o, hv);
          end
        end
        held = bus.o_valid && !bus.o_ready;
        hv   = bus.o;
        if (bus.o_valid && bus.o_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stale o=%h with nothing outstanding", bus.o);
          end else begin
            e = exp_q.pop_front();
            if (bus.o !== e.p) begin
              errors++;
              $display("FAIL result o=%h required %h", bus.o, e.p);
            end
`ifdef FP2P_FLAGS_EN
            else if ({bus.o_inexact, bus.o_sat, bus.o_nar} !== {e.inx, e.sat, e.nar}) begin
              errors++;
              $display("FAIL flags inx/sat/nar=%b required %b",
                       {bus.o_inexact, bus.o_sat, bus.o_nar}, {e.inx, e.sat, e.nar});
            end
`endif
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] dw[15];
    logic [15:0] dp[15];
    logic [31:0] fw[6];
    logic [31:0] w;
    exp_t        e;
    int          j, c0, cov, n;

    dw = '{32'h3F800000, 32'hBF800000, 32'h40000000, 32'h00000000, 32'h80000000,
           32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7E967699, 32'hFE967699,
           32'h006CE3EE, 32'h00000001, 32'h3F800400, 32'h3F800C00, 32'h3F800401};
    dp = '{16'h4000, 16'hC000, 16'h5000, 16'h0000, 16'h0000,
           16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h8001,
           16'h0001, 16'h0001, 16'h4000, 16'h4002, 16'h4001};

    bus.i_valid = 1'b0; bus.i = '0; bus.o_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o !== 16'h0) begin
      errors++;
      $display("FAIL reset_state o_valid=%b o=%h required 0/0000", bus.o_valid, bus.o);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset i_ready=%b required 1", bus.i_ready);
    end

    // Directed vectors, with spec-given results
    rand_ordy = 1'b1;
    for (int x = 0; x < 15; x++) begin
      e = model(dw[x]); e.p = dp[x];
      send(dw[x], e);
    end
    drain();

    // Randomised mix of classes
    for (int x = 0; x < 400; x++) begin
      case ($urandom_range(0, 4))
        0: w = $urandom;
        1: w = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
        2: w = {1'($urandom), 8'h00, 23'($urandom >> $urandom_range(0, 22))};
        3: w = {1'($urandom), ($urandom_range(0, 1) ? 8'($urandom_range(0, 20))
                                                   : 8'($urandom_range(235, 255))), 23'($urandom)};
        default: w = {1'($urandom), 8'($urandom_range(120, 135)), 12'($urandom), 1'b1, 10'h0};
      endcase
      send(w, model(w));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // Flow control: fill with o_ready low, then release
    rand_ordy = 1'b0;
    @(negedge clk); bus.o_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.o_ready = 1'b0;
    for (int x = 0; x < 6; x++) fw[x] = {2'b00, 6'($urandom_range(20, 40)), 24'($urandom)};
    j = 0; c0 = -1; cov = -1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      bus.i = fw[j]; bus.i_valid = 1'b1;
      #1;
      if (bus.o_valid && cov < 0) cov = cyc;
      if (bus.i_ready) begin
        if (c0 < 0) c0 = cyc;
        exp_q.push_back(model(fw[j]));
        j++;
      end
    end
    checks++;
    if (j != 3) begin errors++; $display("FAIL stall_accepts got=%0d required 3", j); end
    checks++;
    if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL stall_ready i_ready=%b required 0", bus.i_ready); end
    checks++;
    if (cov - c0 != 3) begin errors++; $display("FAIL latency got=%0d required 3", cov - c0); end
    n = 0;
    while (j < 6 && n < 50) begin
      @(negedge clk);
      bus.o_ready = 1'b1; bus.i = fw[j];
      #1;
      if (bus.i_ready) begin exp_q.push_back(model(fw[j])); j++; end
      n++;
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    checks++;
    if (j != 6) begin errors++; $display("FAIL release_accepts got=%0d required 6", j); end
    drain();

    // Reset with two words in flight
    @(negedge clk); bus.o_ready = 1'b0;
    send(32'h3F800000, model(32'h3F800000));
    send(32'h40000000, model(32'h40000000));
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset o_valid=%b o=%h required 0/0000", bus.o_valid, bus.o);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_post_reset i_ready=%b required 1", bus.i_ready);
    end
    bus.o_ready = 1'b1;
    repeat (8) @(negedge clk);
    rand_ordy = 1'b1;
    send(32'hBF800000, model(32'hBF800000));
    send(32'h3F800C00, model(32'h3F800C00));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
